aud_recorder: RTL and testbench

- I2S ADC-side deserializer for the lab3 audio path, mirroring the DAC-side player on the receive direction.
- Samples serial codec ADC data on the bit clock and assembles 16-bit MSB-first words.
- Emits each word with an incrementing SRAM address and a one-cycle write strobe.
- Start/pause/stop are driven by the top-level controller; output feeds the SRAM write port.

---
 rtl/aud_recorder.sv | 224 ++++++++++++++++++++++
 tb/tb_aud_recorder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_recorder.sv
// aud_recorder: I2S ADC-side deserializer. Captures 16-bit MSB-first words
// from the codec ADC data line and presents each one to the SRAM write port
// with an incrementing address and a one-cycle write strobe.
//
// Build option: define AUD_REC_STEREO_EN to capture both slots (left at even,
// right at odd addresses). Without it only the left slot is recorded.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | not recording; waiting for i_start
// WAIT   | armed; waiting for the slot edge that starts the next word
// SHIFT  | sampling the DATA_W data bits, MSB first
// WRITE  | word just strobed; count it, advance address, pick next state
// PAUSE  | address and length frozen until i_start
module aud_recorder #(
    parameter int ADDR_W   = 20,
    parameter int MAX_ADDR = 1048575,
    parameter int DATA_W   = 16
) (
    input  logic              i_bclk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_adclrck,
    input  logic              i_adcdat,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [ADDR_W:0]   o_len,
    output logic              o_recording,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_WRITE,
        S_PAUSE
    } state_t;

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic                lrc_q;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                done_q, done_d;

    logic                left_edge;
    logic                cap_edge;
    logic                pause_now_ok;
    logic                pause_at_write;

    // Left slot starts when LRCK falls; the edge cycle itself is the I2S one-bit delay.
    assign left_edge = lrc_q & ~i_adclrck;

`ifdef AUD_REC_STEREO_EN
    logic side_q, side_d;   // 0: next word is left, 1: next word is right
    logic right_edge;

    assign right_edge     = ~lrc_q & i_adclrck;
    assign cap_edge       = side_q ? right_edge : left_edge;
    // A pause may only land between pairs so left/right stay address-aligned.
    assign pause_now_ok   = ~side_q;
    assign pause_at_write = side_q;
`else
    assign cap_edge       = left_edge;
    assign pause_now_ok   = 1'b1;
    assign pause_at_write = 1'b1;
`endif

    // Next-state and datapath decisions; stop beats pause beats start.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = 1'b0;
        len_d   = len_q;
        done_d  = 1'b0;
`ifdef AUD_REC_STEREO_EN
        side_d  = side_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start && !i_pause && !i_stop) begin
                    addr_d  = '0;
                    len_d   = '0;
                    pend_d  = 1'b0;
                    state_d = S_WAIT;
`ifdef AUD_REC_STEREO_EN
                    side_d  = 1'b0;
`endif
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    pend_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (i_pause && pause_now_ok) begin
                    pend_d  = 1'b0;
                    state_d = S_PAUSE;
                end else begin
                    if (i_pause) begin
                        pend_d = 1'b1;
                    end
                    if (cap_edge) begin
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (i_stop) begin
                    // Partial word is simply dropped; nothing was strobed yet.
                    pend_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (i_pause) begin
                        pend_d = 1'b1;
                    end
                    shift_d = {shift_q[DATA_W-3:0], i_adcdat};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        data_d  = {shift_q, i_adcdat};
                        valid_d = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // The word has already gone out on the strobe, so it always counts.
                len_d = len_q + 1'b1;
                if (i_stop || addr_q == MAX_A) begin
                    pend_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + 1'b1;
`ifdef AUD_REC_STEREO_EN
                    side_d = ~side_q;
`endif
                    if ((pend_q || i_pause) && pause_at_write) begin
                        pend_d  = 1'b0;
                        state_d = S_PAUSE;
                    end else begin
                        pend_d  = pend_q | i_pause;
                        state_d = S_WAIT;
                    end
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (i_start && !i_pause) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial word.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            lrc_q   <= 1'b0;
            shift_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lrc_q   <= i_adclrck;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

`ifdef AUD_REC_STEREO_EN
    // Slot tracker: recording always opens on a left word.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            side_q <= 1'b0;
        end else begin
            side_q <= side_d;
        end
    end
`endif

    assign o_address   = addr_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_len       = len_q;
    assign o_done      = done_q;
    assign o_recording = (state_q == S_WAIT) || (state_q == S_SHIFT);

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder (mono build): I2S frames driven cycle by cycle,
// a directed frame table, an async-reset sequence and a randomized run
// checked against a frame-level recording model.
module tb_aud_recorder;

    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 16;
    localparam int MAX_ADDR = 3;

    localparam int EV_NONE  = 0;
    localparam int EV_START = 1;
    localparam int EV_PAUSE = 2;
    localparam int EV_STOP  = 3;

    logic              i_bclk    = 1'b0;
    logic              i_rst_n   = 1'b0;
    logic              i_start   = 1'b0;
    logic              i_pause   = 1'b0;
    logic              i_stop    = 1'b0;
    logic              i_adclrck = 1'b1;
    logic              i_adcdat  = 1'b0;
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic [ADDR_W:0]   o_len;
    logic              o_recording;
    logic              o_done;

    aud_recorder #(
        .ADDR_W  (ADDR_W),
        .MAX_ADDR(MAX_ADDR),
        .DATA_W  (DATA_W)
    ) dut (
        .i_bclk     (i_bclk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_pause    (i_pause),
        .i_stop     (i_stop),
        .i_adclrck  (i_adclrck),
        .i_adcdat   (i_adcdat),
        .o_address  (o_address),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_len      (o_len),
        .o_recording(o_recording),
        .o_done     (o_done)
    );

    always #5 i_bclk = ~i_bclk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          ev;
        int          ev_j;
        int          ns;
        logic [31:0] a;
        logic [15:0] d;
        int          len;
        int          dn;
        int          rec;
    } row_t;

    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;
    wr_t  obs_q[$];
    logic r_lsb    = 1'b0;

    always @(negedge i_bclk) begin
        if (i_rst_n) begin
            if (o_valid) obs_q.push_back('{32'(o_address), o_data});
            if (o_done) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic lrc, input logic dat, input logic st,
                               input logic pa, input logic sp);
        i_adclrck = lrc;
        i_adcdat  = dat;
        i_start   = st;
        i_pause   = pa;
        i_stop    = sp;
        @(posedge i_bclk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " address"},   32'(o_address), 32'h0);
        chk({tag, " data"},      32'(o_data), 32'h0);
        chk({tag, " valid"},     32'(o_valid), 32'h0);
        chk({tag, " len"},       32'(o_len), 32'h0);
        chk({tag, " recording"}, 32'(o_recording), 32'h0);
        chk({tag, " done"},      32'(o_done), 32'h0);
    endtask

    // One 32-bit I2S frame: LRCK low for j=0..15, left MSB at j=1, left LSB at j=16,
    // right bits from j=17, right LSB spills into the next frame's j=0.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int ev,
                              input int ev_j, input int rst_j);
        logic lrc, dat;
        obs_q.delete();
        done_cnt = 0;
        for (int j = 0; j < 32; j++) begin
            lrc = (j < 16) ? 1'b0 : 1'b1;
            if (j == 0)       dat = r_lsb;
            else if (j <= 16) dat = l[4'(16 - j)];
            else              dat = r[4'(32 - j)];
            if (rst_j >= 0 && j == rst_j + 4) i_rst_n = 1'b1;
            drive_cycle(lrc, dat, ev == EV_START && j == ev_j,
                        ev == EV_PAUSE && j == ev_j, ev == EV_STOP && j == ev_j);
            if (j == rst_j) begin
                #2;
                i_rst_n = 1'b0;
                #1;
                check_zero("async_rst");
            end
        end
        r_lsb   = r[0];
        i_start = 1'b0;
        i_pause = 1'b0;
        i_stop  = 1'b0;
        @(negedge i_bclk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int ns, input logic [31:0] a,
                               input logic [15:0] d, input int len, input int dn, input int rec);
        chk({tag, " strobes"}, 32'(obs_q.size()), 32'(ns));
        if (ns == 1 && obs_q.size() == 1) begin
            chk({tag, " address"}, obs_q[0].addr, a);
            chk({tag, " data"}, 32'(obs_q[0].data), 32'(d));
        end
        chk({tag, " len"}, 32'(o_len), 32'(len));
        chk({tag, " done"}, 32'(done_cnt), 32'(dn));
        chk({tag, " recording"}, 32'(o_recording), 32'(rec));
    endtask

    row_t tbl[21];

    initial begin
        int          m_state;
        int          m_addr;
        int          m_len;
        int          ev, ev_j, ns, dn;
        logic [15:0] l, r;
        logic [31:0] ea;
        logic [15:0] ed;
        logic        full, written;

        // l, r, ev, ev_j, strobes, addr, data, len, done, recording
        tbl[0]  = '{16'h1111, 16'h0000, EV_START, 5,  0, 0, 16'h0,    0, 0, 1};
        tbl[1]  = '{16'hAAAA, 16'h5555, EV_NONE,  0,  1, 0, 16'hAAAA, 1, 0, 1};
        tbl[2]  = '{16'h3C3C, 16'h0F0F, EV_STOP,  8,  0, 0, 16'h0,    1, 1, 0};
        tbl[3]  = '{16'h2222, 16'h0000, EV_START, 20, 0, 0, 16'h0,    0, 0, 1};
        tbl[4]  = '{16'h0FFF, 16'hFFFF, EV_NONE,  0,  1, 0, 16'h0FFF, 1, 0, 1};
        tbl[5]  = '{16'hFF0F, 16'hFFFF, EV_NONE,  0,  1, 1, 16'hFF0F, 2, 0, 1};
        tbl[6]  = '{16'h1357, 16'h2468, EV_PAUSE, 5,  1, 2, 16'h1357, 3, 0, 0};
        tbl[7]  = '{16'h4242, 16'h0001, EV_NONE,  0,  0, 0, 16'h0,    3, 0, 0};
        tbl[8]  = '{16'h7E7E, 16'h8000, EV_NONE,  0,  0, 0, 16'h0,    3, 0, 0};
        tbl[9]  = '{16'h6006, 16'hFFFF, EV_NONE,  0,  0, 0, 16'h0,    3, 0, 0};
        tbl[10] = '{16'h4444, 16'h1234, EV_START, 3,  0, 0, 16'h0,    3, 0, 1};
        tbl[11] = '{16'h8001, 16'hFFFF, EV_NONE,  0,  1, 3, 16'h8001, 4, 1, 0};
        tbl[12] = '{16'h7777, 16'h0000, EV_NONE,  0,  0, 0, 16'h0,    4, 0, 0};
        tbl[13] = '{16'h9999, 16'h0000, EV_START, 0,  0, 0, 16'h0,    0, 0, 1};
        tbl[14] = '{16'h0000, 16'hFFFF, EV_STOP,  16, 0, 0, 16'h0,    0, 1, 0};
        tbl[15] = '{16'h1010, 16'h0101, EV_START, 12, 0, 0, 16'h0,    0, 0, 1};
        tbl[16] = '{16'hBEEF, 16'h0000, EV_PAUSE, 0,  0, 0, 16'h0,    0, 0, 0};
        tbl[17] = '{16'hCAFE, 16'hFFFF, EV_NONE,  0,  0, 0, 16'h0,    0, 0, 0};
        tbl[18] = '{16'hF00D, 16'h0000, EV_START, 31, 0, 0, 16'h0,    0, 0, 1};
        tbl[19] = '{16'hABCD, 16'h5A5A, EV_NONE,  0,  1, 0, 16'hABCD, 1, 0, 1};
        tbl[20] = '{16'h5A5A, 16'hA5A5, EV_STOP,  25, 1, 1, 16'h5A5A, 2, 1, 0};

        // Power-on reset.
        repeat (3) @(posedge i_bclk);
        #1;
        check_zero("reset");
        i_rst_n = 1'b1;
        repeat (2) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle recording", 32'(o_recording), 32'h0);

        // Directed frame table.
        for (int i = 0; i < 21; i++) begin
            send_frame(tbl[i].l, tbl[i].r, tbl[i].ev, tbl[i].ev_j, -1);
            check_frame($sformatf("row%0d", i), tbl[i].ns, tbl[i].a, tbl[i].d,
                        tbl[i].len, tbl[i].dn, tbl[i].rec);
        end

        // Async reset in the middle of a word.
        send_frame(16'h0000, 16'h0000, EV_START, 10, -1);
        send_frame(16'hC3A5, 16'h0000, EV_NONE, 0, -1);
        check_frame("pre_rst", 1, 0, 16'hC3A5, 1, 0, 1);
        send_frame(16'h9F9F, 16'h0000, EV_NONE, 0, 8);
        check_frame("rst_frame", 0, 0, 16'h0, 0, 0, 0);
        send_frame(16'h1F1F, 16'h0000, EV_NONE, 0, -1);
        check_frame("post_rst", 0, 0, 16'h0, 0, 0, 0);

        // Randomized frames against a frame-level recording model.
        m_state = 0;
        m_addr  = 0;
        m_len   = 0;
        for (int f = 0; f < 80; f++) begin
            case ($urandom_range(0, 7))
                0, 1:    ev = EV_START;
                2:       ev = EV_PAUSE;
                3:       ev = EV_STOP;
                default: ev = EV_NONE;
            endcase
            ev_j = $urandom_range(0, 31);
            if (ev != EV_START && ev_j == 17) ev_j = 18;
            l  = 16'($urandom);
            r  = 16'($urandom);
            ns = 0;
            dn = 0;
            ea = 0;
            ed = 0;
            if (m_state == 1) begin
                full    = 1'b0;
                written = !((ev == EV_STOP && ev_j <= 16) || (ev == EV_PAUSE && ev_j == 0));
                if (written) begin
                    ns = 1;
                    ea = 32'(m_addr);
                    ed = l;
                    m_len++;
                    if (m_addr == MAX_ADDR) begin
                        full    = 1'b1;
                        m_state = 0;
                        dn++;
                    end else begin
                        m_addr++;
                    end
                end
                if (!full) begin
                    if (ev == EV_STOP) begin
                        m_state = 0;
                        dn++;
                    end else if (ev == EV_PAUSE) begin
                        m_state = 2;
                    end
                end
            end else if (m_state == 2) begin
                if (ev == EV_STOP) begin
                    m_state = 0;
                    dn++;
                end else if (ev == EV_START) begin
                    m_state = 1;
                end
            end else begin
                if (ev == EV_START) begin
                    m_state = 1;
                    m_addr  = 0;
                    m_len   = 0;
                end
            end
            send_frame(l, r, ev, ev_j, -1);
            check_frame($sformatf("rnd%0d", f), ns, ea, ed, m_len, dn, (m_state == 1) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
